// File: rtl/fir_ctrl_pkg.sv
//------------------------------------------------------------------------------
// fir_ctrl_pkg : shared state encoding and defaults for the FIR sample sequencer
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fir_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int CLR_CYCLES_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/fir_rom_sequencer.sv
//------------------------------------------------------------------------------
// fir_rom_sequencer : replays a frame from the mu/mic sample memories into the
//                     adaptive FIR, clearing the filter before each run
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_rom_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int NB_DEPTH   = 14,
   parameter int CLR_CYCLES = CLR_CYCLES_DEFAULT,
   parameter int NB_FRAME   = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_loop,
   input  logic [NB_DEPTH-1:0] i_last_addr,
   output logic [NB_DEPTH-1:0] o_addr,
   output logic                o_rd_en,
   output logic                o_valid,
   output logic                o_fir_rst,
   output logic                o_busy,
   output logic                o_done,
   output logic [NB_FRAME-1:0] o_frame_cnt
);

   localparam int                NB_CLR   = $clog2(CLR_CYCLES + 1);
   localparam logic [NB_CLR-1:0] CLR_LOAD = NB_CLR'(CLR_CYCLES);

   state_e              state_q, state_d;
   logic [NB_CLR-1:0]   clr_q, clr_d;
   logic [NB_DEPTH-1:0] last_q, last_d;
   logic [NB_DEPTH-1:0] addr_q, addr_d;
   logic [NB_FRAME-1:0] frame_q, frame_d;
   logic                rd_en_q, valid_q, fir_rst_q, busy_q, done_q;
   logic                frame_end;

   assign frame_end = (addr_q == last_q);

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      last_d  = last_q;
      addr_d  = addr_q;
      frame_d = frame_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               last_d  = i_last_addr;
               frame_d = '0;
               clr_d   = CLR_LOAD;
               addr_d  = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (i_stop) begin
               clr_d   = '0;
               state_d = ST_DONE;
            end else if (clr_q <= NB_CLR'(1)) begin
               clr_d   = '0;
               addr_d  = '0;
               state_d = ST_RUN;
            end else begin
               clr_d = clr_q - NB_CLR'(1);
            end
         end
         ST_RUN: begin
            // A stop that lands on the frame's last address still counts the frame
            if (frame_end) begin
               if (frame_q != '1) frame_d = frame_q + NB_FRAME'(1);
               if (i_loop && !i_stop) addr_d  = '0;
               else                   state_d = ST_DRAIN;
            end else if (i_stop) begin
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + NB_DEPTH'(1);
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         clr_q     <= '0;
         last_q    <= '0;
         addr_q    <= '0;
         frame_q   <= '0;
         rd_en_q   <= 1'b0;
         valid_q   <= 1'b0;
         fir_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_q     <= clr_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         frame_q   <= frame_d;
         rd_en_q   <= (state_d == ST_RUN);
         valid_q   <= rd_en_q;
         fir_rst_q <= (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign o_addr      = addr_q;
   assign o_rd_en     = rd_en_q;
   assign o_valid     = valid_q;
   assign o_fir_rst   = fir_rst_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_frame_cnt = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_rom_sequencer.sv
//------------------------------------------------------------------------------
// tb_fir_rom_sequencer : directed scenarios with a read/done scoreboard
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_rom_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [13:0] last = '0;
   logic [13:0] addr;
   logic        rd_en, valid, fir_rst, busy, done;
   logic [7:0]  fcnt;

   logic        b_start = 1'b0, b_stop = 1'b0, b_loop = 1'b0;
   logic [13:0] b_last = '0;
   logic [13:0] b_addr;
   logic        b_rd_en, b_valid, b_fir_rst, b_busy, b_done;
   logic [1:0]  b_fcnt;

   int errors = 0;
   int checks = 0;
   int exp_addr[$];
   int exp_cnt[$];
   logic prev_rd = 1'b0;
   logic rst_s   = 1'b1;

   always #5 clk = ~clk;

   fir_rom_sequencer u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
      .i_last_addr(last), .o_addr(addr), .o_rd_en(rd_en), .o_valid(valid),
      .o_fir_rst(fir_rst), .o_busy(busy), .o_done(done), .o_frame_cnt(fcnt)
   );

   fir_rom_sequencer #(.NB_FRAME(2)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_stop(b_stop), .i_loop(b_loop),
      .i_last_addr(b_last), .o_addr(b_addr), .o_rd_en(b_rd_en), .o_valid(b_valid),
      .o_fir_rst(b_fir_rst), .o_busy(b_busy), .o_done(b_done), .o_frame_cnt(b_fcnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) rst_s = rst;

   // Monitor: every read and every done pulse consumes one scoreboard entry
   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         if (exp_addr.size() == 0) chk("unexpected_read", 32'(addr), 32'hFFFF);
         else chk("sb_addr", 32'(addr), 32'(exp_addr.pop_front()));
      end
      if (done === 1'b1) begin
         if (exp_cnt.size() == 0) chk("unexpected_done", 32'(fcnt), 32'hFFFF);
         else chk("sb_frame_cnt", 32'(fcnt), 32'(exp_cnt.pop_front()));
      end
      chk("valid_lag", 32'(valid), 32'(prev_rd && !rst_s));
      prev_rd = rd_en;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_reads(input int n, input int max, output int got, output int gaps);
      got = 0; gaps = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (rd_en) got++;
         else if (got > 0) gaps++;
         if (got == n) break;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},    32'(addr),    0);
      chk({tag, "_rd_en"},   32'(rd_en),   0);
      chk({tag, "_valid"},   32'(valid),   0);
      chk({tag, "_done"},    32'(done),    0);
      chk({tag, "_fcnt"},    32'(fcnt),    0);
      chk({tag, "_fir_rst"}, 32'(fir_rst), 1);
      chk({tag, "_busy"},    32'(busy),    0);
   endtask

   initial begin
      int clr, dones, reads, got, gaps, busy_seen;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("reset");

      // Single run over addresses 0..3; last-address change while busy is ignored
      for (int a = 0; a <= 3; a++) exp_addr.push_back(a);
      exp_cnt.push_back(1);
      last = 14'd3; loop = 1'b0;
      pulse_start();
      last = 14'd50;
      clr = 0; dones = 0; reads = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy && fir_rst && !done) clr++;
         if (rd_en) reads++;
         if (done) begin dones++; break; end
      end
      chk("t1_clear_cycles", 32'(clr), 16);
      chk("t1_reads", 32'(reads), 4);
      chk("t1_done_pulses", 32'(dones), 1);
      @(negedge clk);
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_frame_cnt", 32'(fcnt), 1);
      chk("t1_done_one_cycle", 32'(done), 0);

      // Loop mode, stop on the 9th RUN cycle (frame end of the third pass)
      for (int f = 0; f < 3; f++) for (int a = 0; a <= 2; a++) exp_addr.push_back(a);
      exp_cnt.push_back(3);
      last = 14'd2; loop = 1'b1;
      pulse_start();
      wait_reads(9, 60, got, gaps);
      chk("t2_reads", 32'(got), 9);
      chk("t2_gaps", 32'(gaps), 0);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0; loop = 1'b0;
      @(negedge clk);
      chk("t2_drain_rd_en", 32'(rd_en), 0);
      chk("t2_drain_valid", 32'(valid), 1);
      chk("t2_drain_busy", 32'(busy), 1);
      chk("t2_drain_fir_rst", 32'(fir_rst), 0);
      @(negedge clk);
      chk("t2_done", 32'(done), 1);
      @(negedge clk);

      // Abort mid-frame at address 10
      for (int a = 0; a <= 10; a++) exp_addr.push_back(a);
      exp_cnt.push_back(0);
      last = 14'd100;
      pulse_start();
      wait_reads(11, 60, got, gaps);
      chk("t3_reads", 32'(got), 11);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      chk("t3_drain_rd_en", 32'(rd_en), 0);
      chk("t3_drain_addr", 32'(addr), 10);
      @(negedge clk);
      chk("t3_done", 32'(done), 1);
      @(negedge clk);

      // Start together with stop in IDLE is ignored
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      busy_seen = 0; reads = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (rd_en) reads++;
      end
      chk("t4_busy", 32'(busy_seen), 0);
      chk("t4_reads", 32'(reads), 0);

      // Reset in the middle of RUN at address 50
      for (int a = 0; a <= 50; a++) exp_addr.push_back(a);
      last = 14'd100;
      pulse_start();
      wait_reads(51, 100, got, gaps);
      chk("t5_reads", 32'(got), 51);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("t5_midrun");
      repeat (5) @(negedge clk);
      chk("t5_stays_idle", 32'(busy), 0);

      // Frame-counter saturation with a 2-bit counter and one-sample frames
      b_last = 14'd0; b_loop = 1'b1;
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b_rd_en) begin got = 1; break; end
      end
      chk("t6_first_read", 32'(got), 1);
      for (int k = 1; k <= 6; k++) begin
         chk("t6_rd_en", 32'(b_rd_en), 1);
         chk("t6_addr", 32'(b_addr), 0);
         chk("t6_cnt_run", 32'(b_fcnt), 32'((k - 1 > 3) ? 3 : k - 1));
         if (k < 6) @(negedge clk);
      end
      #1 b_stop = 1'b1;
      @(posedge clk); #1 b_stop = 1'b0; b_loop = 1'b0;
      @(negedge clk);
      chk("t6_cnt_sat", 32'(b_fcnt), 3);
      @(negedge clk);
      chk("t6_done", 32'(b_done), 1);
      chk("t6_done_cnt", 32'(b_fcnt), 3);

      repeat (3) @(negedge clk);
      chk("sb_addr_left", 32'(exp_addr.size()), 0);
      chk("sb_cnt_left", 32'(exp_cnt.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timed out");
   end

endmodule

`default_nettype wire
